instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 112 +++++++++++
 tb/tb_instr_fetch_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers in-order responses with their PCs,
// and flushes/redirects on branch resolution, dropping stale responses still in flight.
module instr_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [31:0]                imem_rsp_instr,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic            req_fire;
    logic            rsp_take;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic [CW:0]     occupancy;
    logic [CW-1:0]   inflight_next;
    logic [XLEN-1:0] redirect_aligned;

    // Outstanding requests count against capacity so every response is guaranteed a slot.
    assign occupancy        = {1'b0, count_q} + {1'b0, inflight};
    assign imem_req_valid   = reset_n && (occupancy < DEPTH_W) && !redirect_valid;
    assign imem_req_addr    = fetch_pc & ALIGN_MASK;
    assign req_fire         = imem_req_valid && imem_req_ready;

    // A response with nothing in flight is spurious and ignored entirely.
    assign rsp_take         = imem_rsp_valid && (inflight != '0);
    assign rsp_drop         = rsp_take && (drop_cnt != '0);
    assign push             = rsp_take && (drop_cnt == '0) && !redirect_valid;
    assign inflight_next    = inflight + CW'(req_fire) - CW'(rsp_take);
    assign redirect_aligned = redirect_pc & ALIGN_MASK;

    assign out_valid = (count_q != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_instr = (count_q != '0) ? instr_mem[rd_ptr] : '0;
    assign out_pc    = (count_q != '0) ? pc_mem[rd_ptr]    : '0;
    assign count     = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            count_q  <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= redirect_aligned;
                rsp_pc   <= redirect_aligned;
                count_q  <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                drop_cnt <= inflight_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    rsp_pc <= rsp_pc + XLEN'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rsp_instr;
            pc_mem[wr_ptr]    <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: a behavioural memory with in-order variable latency,
// an epoch-tagged request model, and a scoreboard of expected {instr, pc} leaving the queue.
module tb_instr_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clk;
    logic              reset_n;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_instr;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [XLEN-1:0]   out_pc;
    logic [$clog2(DEPTH):0] count;

    instr_fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_instr (imem_rsp_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .count          (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          due;
        int          epoch;
    } pend_t;

    pend_t       pend[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_fetch_pc;
    int          epoch;
    int          cyc;
    int          p_ready;
    int          p_out;
    int          p_redir;
    int          max_lat;
    bit          release_pending;
    int          vectors;
    int          miscompares;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_instr = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        pend.delete();
        exp_q.delete();
        exp_fetch_pc = RESET_PC;
        epoch++;
        repeat (2) @(negedge clk);
        release_pending = 1'b1;
    endtask

    task automatic one_cycle();
        pend_t       h;
        logic        rsp;
        logic        redir;
        logic        fire;
        logic [31:0] rpc;
        @(negedge clk);
        if (release_pending) begin
            reset_n         = 1'b1;
            release_pending = 1'b0;
        end
        cyc++;
        imem_req_ready = ($urandom_range(99) < p_ready);
        out_ready      = ($urandom_range(99) < p_out);
        redir          = ($urandom_range(99) < p_redir);
        rpc            = $urandom;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rsp            = (pend.size() != 0) && (pend[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_instr = rsp ? pend[0].instr : $urandom;
        #1;
        fire = imem_req_valid && imem_req_ready;
        @(posedge clk);
        if (rsp) begin
            h = pend.pop_front();
            if (!redir && h.epoch == epoch) exp_q.push_back({h.instr, h.addr});
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            exp_fetch_pc = rpc & ~32'h3;
        end else if (fire) begin
            pend.push_back('{exp_fetch_pc, $urandom, cyc + 1 + int'($urandom_range(max_lat)), epoch});
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
    endtask

    task automatic run(input int n, input int pr, input int po, input int pd, input int ml);
        p_ready = pr;
        p_out   = po;
        p_redir = pd;
        max_lat = ml;
        for (int i = 0; i < n; i++) one_cycle();
    endtask

    // monitor / scoreboard
    initial begin
        logic [63:0] e;
        logic        exp_req_v;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_out_instr", 64'(out_instr), 64'd0);
                chk("rst_out_pc", 64'(out_pc), 64'd0);
                chk("rst_count", 64'(count), 64'd0);
            end else begin
                chk("count", 64'(count), 64'(exp_q.size()));
                exp_req_v = ((exp_q.size() + pend.size()) < DEPTH) && !redirect_valid;
                chk("req_valid", 64'(imem_req_valid), 64'(exp_req_v));
                chk("out_valid", 64'(out_valid), 64'((exp_q.size() != 0) && !redirect_valid));
                if (imem_req_valid && imem_req_ready) begin
                    chk("req_addr", 64'(imem_req_addr), 64'(exp_fetch_pc));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_unexpected", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_instr", 64'(out_instr), 64'(e[63:32]));
                        chk("out_pc", 64'(out_pc), 64'(e[31:0]));
                    end
                end
            end
        end
    end

    // stimulus phases and final report
    initial begin
        reset_n         = 1'b0;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_instr  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        out_ready       = 1'b0;
        exp_fetch_pc    = RESET_PC;
        epoch           = 0;
        cyc             = 0;
        vectors         = 0;
        miscompares     = 0;
        release_pending = 1'b0;
        p_ready = 0; p_out = 0; p_redir = 0; max_lat = 0;

        do_reset();
        run(40, 100, 100, 0, 0);     // streaming from RESET_PC, 1-cycle memory
        run(20, 100, 0, 0, 0);       // fill and stall
        run(1, 100, 100, 0, 0);      // single pop frees one slot
        run(6, 100, 0, 0, 0);
        do_reset();                  // reset with queue full
        run(30, 100, 100, 0, 0);
        run(3000, 60, 60, 5, 3);     // random handshake, latency and redirects
        run(1000, 80, 70, 25, 3);    // redirect-heavy
        run(50, 100, 0, 0, 2);
        do_reset();
        run(300, 70, 80, 5, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
